load_store_unit: RTL

- Consumes the memory effective address, opcode and rt store data produced by the execute stage.
- Runs one Avalon-MM-style read or write per instruction on the data-memory bus.
- Handles byte-lane steering and byte-enables for sub-word accesses, and sign or zero extension of load data.
- Returns a register writeback response to the CPU.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one Avalon-MM read or write per memory instruction, with lane steering and load extension.
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned accesses skip the bus and report align_err.
//
// state   | meaning
// IDLE    | ready for a request; req_ready=1
// READ    | mem_read asserted, waiting for mem_waitrequest=0
// WRITE   | mem_write asserted, waiting for mem_waitrequest=0
// RESP    | one-cycle resp_valid pulse back to the CPU
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rt,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rt,
  output logic              align_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic [5:0]  r_opcode;
  logic [1:0]  r_addr_lo;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign req_ready = (r_state == S_IDLE);

  always_comb begin
    w_is_load  = (req_opcode == OP_LB) || (req_opcode == OP_LH) || (req_opcode == OP_LW) ||
                 (req_opcode == OP_LBU) || (req_opcode == OP_LHU);
    w_is_store = (req_opcode == OP_SB) || (req_opcode == OP_SH) || (req_opcode == OP_SW);
    w_is_half  = (req_opcode == OP_LH) || (req_opcode == OP_LHU) || (req_opcode == OP_SH);
    w_is_word  = (req_opcode == OP_LW) || (req_opcode == OP_SW);
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Lane enables and store data are computed from the request and registered at accept.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_opcode)
      OP_LB, OP_LBU, OP_SB: w_be = 4'b0001 << req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: w_be = req_addr[1] ? 4'b1100 : 4'b0011;
      default:              w_be = 4'b1111;
    endcase
    case (req_opcode)
      OP_SB:   w_wdata = {4{req_wdata[7:0]}};
      OP_SH:   w_wdata = {2{req_wdata[15:0]}};
      default: w_wdata = req_wdata;
    endcase
  end

  always_comb begin
    w_byte = mem_readdata[7:0];
    case (r_addr_lo)
      2'd0: w_byte = mem_readdata[7:0];
      2'd1: w_byte = mem_readdata[15:8];
      2'd2: w_byte = mem_readdata[23:16];
      2'd3: w_byte = mem_readdata[31:24];
      default: w_byte = mem_readdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (r_opcode)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_readdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_opcode       <= '0;
      r_addr_lo      <= '0;
      resp_valid     <= 1'b0;
      resp_we        <= 1'b0;
      resp_rdata     <= '0;
      resp_rt        <= '0;
      align_err      <= 1'b0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_opcode  <= req_opcode;
            r_addr_lo <= req_addr[1:0];
            resp_rt   <= req_rt;
            if (w_misaligned) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_we    <= 1'b0;
              resp_rdata <= '0;
              align_err  <= 1'b1;
            end else if (w_is_load || w_is_store) begin
              r_state        <= w_is_load ? S_READ : S_WRITE;
              mem_read       <= w_is_load;
              mem_write      <= w_is_store;
              mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_byteenable <= w_be;
              mem_writedata  <= w_wdata;
            end else begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_we    <= 1'b0;
              resp_rdata <= '0;
              align_err  <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (!mem_waitrequest) begin
            r_state    <= S_RESP;
            mem_read   <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= 1'b1;
            resp_rdata <= w_load_data;
            align_err  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!mem_waitrequest) begin
            r_state    <= S_RESP;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= 1'b0;
            resp_rdata <= '0;
            align_err  <= 1'b0;
          end
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
          resp_we    <= 1'b0;
          align_err  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
